// File: rtl/hssim_multi_select.sv
// HSSIM multi-candidate decision stage: per-pixel SSIM num/den for every
// candidate map, registered pairwise selection tree, replace mask and stats.
module hssim_multi_select #(
  parameter int          PIXELS_PER_BEAT = 16,
  parameter int          IMAGE_DIM       = 512,
  parameter int          NUM_CAND        = 3,
  parameter logic [16:0] C1              = 17'd6,
  parameter logic [16:0] C2              = 17'd58,
  localparam int         P     = PIXELS_PER_BEAT,
  localparam int         L     = $clog2(NUM_CAND),
  localparam int         IDX_W = (L > 0) ? L : 1,
  localparam int         LAT   = 4 + L
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      stall,
  input  logic                      in_valid,
  input  logic [8*P-1:0]            mu_y,
  input  logic [16*P-1:0]           sig_sq_y,
  input  logic [8*P*NUM_CAND-1:0]   mu_c,
  input  logic [16*P*NUM_CAND-1:0]  sig_sq_c,
  input  logic [16*P*NUM_CAND-1:0]  sig_cy,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [IDX_W*P-1:0]        out_idx,
  output logic [8*P-1:0]            out_del,
  output logic [31:0]               replace_cnt,
  output logic                      cnt_valid
);

  localparam int BEATS = IMAGE_DIM * IMAGE_DIM / P;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [16:0] a_q  [P][NUM_CAND];
  logic [16:0] b_q  [P][NUM_CAND];
  logic [16:0] e_q  [P][NUM_CAND];
  logic [16:0] f_q  [P][NUM_CAND];
  logic [17:0] n1_q [P][NUM_CAND];
  logic [17:0] d1_q [P][NUM_CAND];
  logic [17:0] n2_q [P][NUM_CAND];
  logic [17:0] d2_q [P][NUM_CAND];
  logic [35:0] num_q [P][NUM_CAND];
  logic [35:0] den_q [P][NUM_CAND];

  logic [L+2:0] vp;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vp <= '0;
      for (int j = 0; j < P; j++) begin
        for (int c = 0; c < NUM_CAND; c++) begin
          a_q[j][c]   <= '0;
          b_q[j][c]   <= '0;
          e_q[j][c]   <= '0;
          f_q[j][c]   <= '0;
          n1_q[j][c]  <= '0;
          d1_q[j][c]  <= '0;
          n2_q[j][c]  <= '0;
          d2_q[j][c]  <= '0;
          num_q[j][c] <= '0;
          den_q[j][c] <= '0;
        end
      end
    end else if (!stall) begin
      vp <= {vp[L+1:0], in_valid};
      for (int j = 0; j < P; j++) begin
        for (int c = 0; c < NUM_CAND; c++) begin
          a_q[j][c] <= (17'(mu_c[(c*P+j)*8 +: 8])
                      * 17'(mu_y[j*8 +: 8])) << 1;
          b_q[j][c] <= 17'(mu_c[(c*P+j)*8 +: 8])
                     * 17'(mu_c[(c*P+j)*8 +: 8])
                     + 17'(mu_y[j*8 +: 8])
                     * 17'(mu_y[j*8 +: 8]);
          e_q[j][c] <= {sig_cy[(c*P+j)*16 +: 16], 1'b0};
          f_q[j][c] <= 17'(sig_sq_c[(c*P+j)*16 +: 16])
                     + 17'(sig_sq_y[j*16 +: 16]);
          n1_q[j][c]  <= 18'(a_q[j][c]) + 18'(C1);
          d1_q[j][c]  <= 18'(b_q[j][c]) + 18'(C1);
          n2_q[j][c]  <= 18'(e_q[j][c]) + 18'(C2);
          d2_q[j][c]  <= 18'(f_q[j][c]) + 18'(C2);
          num_q[j][c] <= 36'(n1_q[j][c]) * 36'(n2_q[j][c]);
          den_q[j][c] <= 36'(d1_q[j][c]) * 36'(d2_q[j][c]);
        end
      end
    end
  end

  logic [35:0]      t_num [L+1][P][NUM_CAND];
  logic [35:0]      t_den [L+1][P][NUM_CAND];
  logic [IDX_W-1:0] t_idx [L+1][P][NUM_CAND];

  for (genvar j = 0; j < P; j++) begin : g_l0
    for (genvar c = 0; c < NUM_CAND; c++) begin : g_c
      assign t_num[0][j][c] = num_q[j][c];
      assign t_den[0][j][c] = den_q[j][c];
      assign t_idx[0][j][c] = IDX_W'(c);
    end
  end

  // Node i of level k merges nodes 2i and 2i+1 of level k-1
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int NP = (NUM_CAND + (1 << (k-1)) - 1) >> (k-1);
    for (genvar i = 0; i < NUM_CAND; i++) begin : g_node
      for (genvar j = 0; j < P; j++) begin : g_pix
        if (2*i+1 < NP) begin : g_cmp
          logic [35:0]      nq;
          logic [35:0]      dq;
          logic [IDX_W-1:0] iq;
          logic             r_win;
          assign r_win = 72'(t_num[k-1][j][2*i+1]) * 72'(t_den[k-1][j][2*i])
                       > 72'(t_num[k-1][j][2*i]) * 72'(t_den[k-1][j][2*i+1]);
          always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
              nq <= '0;
              dq <= '0;
              iq <= '0;
            end else if (!stall) begin
              nq <= r_win ? t_num[k-1][j][2*i+1] : t_num[k-1][j][2*i];
              dq <= r_win ? t_den[k-1][j][2*i+1] : t_den[k-1][j][2*i];
              iq <= r_win ? t_idx[k-1][j][2*i+1] : t_idx[k-1][j][2*i];
            end
          end
          assign t_num[k][j][i] = nq;
          assign t_den[k][j][i] = dq;
          assign t_idx[k][j][i] = iq;
        end else if (2*i < NP) begin : g_pass
          logic [35:0]      nq;
          logic [35:0]      dq;
          logic [IDX_W-1:0] iq;
          always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
              nq <= '0;
              dq <= '0;
              iq <= '0;
            end else if (!stall) begin
              nq <= t_num[k-1][j][2*i];
              dq <= t_den[k-1][j][2*i];
              iq <= t_idx[k-1][j][2*i];
            end
          end
          assign t_num[k][j][i] = nq;
          assign t_den[k][j][i] = dq;
          assign t_idx[k][j][i] = iq;
        end else begin : g_nil
          assign t_num[k][j][i] = '0;
          assign t_den[k][j][i] = '0;
          assign t_idx[k][j][i] = '0;
        end
      end
    end
  end

  logic [IDX_W-1:0] win [P];
  logic [31:0]      pc;
  logic [31:0]      run_cnt;
  logic [BCW-1:0]   beat_cnt;
  logic             beat_in;
  logic             last_now;

  always_comb begin
    pc = '0;
    for (int j = 0; j < P; j++) begin
      win[j] = t_idx[L][j][0];
      pc     = pc + 32'(win[j] != '0);
    end
  end

  assign beat_in  = vp[L+2];
  assign last_now = (beat_cnt == BCW'(BEATS-1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_idx     <= '0;
      out_del     <= '0;
      replace_cnt <= '0;
      cnt_valid   <= 1'b0;
      run_cnt     <= '0;
      beat_cnt    <= '0;
    end else if (!stall) begin
      out_valid <= beat_in;
      out_last  <= beat_in && last_now;
      cnt_valid <= beat_in && last_now;
      for (int j = 0; j < P; j++) begin
        out_idx[j*IDX_W +: IDX_W] <= win[j];
        out_del[j*8 +: 8]         <= (win[j] != '0) ? 8'd255 : 8'd0;
      end
      if (beat_in) begin
        if (last_now) begin
          beat_cnt    <= '0;
          replace_cnt <= run_cnt + pc;
          run_cnt     <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          run_cnt  <= run_cnt + pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_hssim_multi_select.sv
// Directed bench for hssim_multi_select: two-candidate instance for latency,
// frames, stall and reset; three-candidate instance for tree selection.
module tb_hssim_multi_select;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic         stall2 = 1'b0, v2 = 1'b0;
  logic [31:0]  muy2;
  logic [63:0]  sqy2;
  logic [63:0]  muc2;
  logic [127:0] sqc2, cy2;
  logic         o2_valid, o2_last, o2_cv;
  logic [3:0]   o2_idx;
  logic [31:0]  o2_del, o2_rep;

  logic         stall3 = 1'b0, v3 = 1'b0;
  logic [31:0]  muy3;
  logic [63:0]  sqy3;
  logic [95:0]  muc3;
  logic [191:0] sqc3, cy3;
  logic         o3_valid, o3_last, o3_cv;
  logic [7:0]   o3_idx;
  logic [31:0]  o3_del, o3_rep;

  hssim_multi_select #(
    .PIXELS_PER_BEAT(4), .IMAGE_DIM(8), .NUM_CAND(2)
  ) u2 (
    .clk(clk), .aresetn(aresetn), .stall(stall2), .in_valid(v2),
    .mu_y(muy2), .sig_sq_y(sqy2), .mu_c(muc2), .sig_sq_c(sqc2),
    .sig_cy(cy2), .out_valid(o2_valid), .out_last(o2_last),
    .out_idx(o2_idx), .out_del(o2_del), .replace_cnt(o2_rep),
    .cnt_valid(o2_cv)
  );

  hssim_multi_select #(
    .PIXELS_PER_BEAT(4), .IMAGE_DIM(8), .NUM_CAND(3)
  ) u3 (
    .clk(clk), .aresetn(aresetn), .stall(stall3), .in_valid(v3),
    .mu_y(muy3), .sig_sq_y(sqy3), .mu_c(muc3), .sig_sq_c(sqc3),
    .sig_cy(cy3), .out_valid(o3_valid), .out_last(o3_last),
    .out_idx(o3_idx), .out_del(o3_del), .replace_cnt(o3_rep),
    .cnt_valid(o3_cv)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] d;
    for (int j = 0; j < 4; j++) d[j*8 +: 8] = m[j] ? 8'd255 : 8'd0;
    return d;
  endfunction

  // mask bit j set: lane j favours candidate 1 (cov = var), else a tie
  task automatic set2(input logic [3:0] m);
    for (int j = 0; j < 4; j++) begin
      muy2[j*8 +: 8]   = 8'd100;
      sqy2[j*16 +: 16] = 16'd1000;
      for (int c = 0; c < 2; c++) begin
        muc2[(c*4+j)*8 +: 8]   = 8'd100;
        sqc2[(c*4+j)*16 +: 16] = 16'd1000;
        cy2[(c*4+j)*16 +: 16]  = (c == 1 && m[j]) ? 16'd1000 : 16'd0;
      end
    end
  endtask

  task automatic set3();
    logic [15:0] cyt [4][3];
    cyt[0] = '{16'd0, 16'd500, 16'd1000};
    cyt[1] = '{16'd0, 16'd1000, 16'd500};
    cyt[2] = '{16'd0, 16'd0, 16'd0};
    cyt[3] = '{16'd0, 16'd0, 16'd0};
    for (int j = 0; j < 4; j++) begin
      muy3[j*8 +: 8]   = 8'd100;
      sqy3[j*16 +: 16] = 16'd1000;
      for (int c = 0; c < 3; c++) begin
        muc3[(c*4+j)*8 +: 8]   = 8'd100;
        sqc3[(c*4+j)*16 +: 16] = 16'd1000;
        cy3[(c*4+j)*16 +: 16]  = cyt[j][c];
      end
    end
  endtask

  logic [3:0] q[$];
  logic       mon_en = 1'b0;
  int         beat_no = 0;
  int         acc = 0;
  int         seen = 0;
  int         pulses = 0;

  always @(negedge clk) begin
    if (mon_en && !stall2) begin
      if (o2_valid && q.size() != 0) begin
        logic [3:0] m;
        m = q.pop_front();
        check("idx", 64'(o2_idx), 64'(m));
        check("del", 64'(o2_del), 64'(expand(m)));
        check("last", 64'(o2_last), 64'(beat_no == 15));
        check("cnt_valid", 64'(o2_cv), 64'(beat_no == 15));
        acc += $countones(m);
        if (beat_no == 15) begin
          check("replace_cnt", 64'(o2_rep), 64'(acc));
          acc = 0;
          beat_no = 0;
        end else begin
          beat_no++;
        end
        seen++;
      end else if (o2_valid) begin
        seen++;
      end else begin
        check("cv_idle", 64'(o2_cv), 64'd0);
      end
      if (o2_cv) pulses++;
    end
  end

  logic [3:0] fr [2][16];
  int n;
  logic       sv;
  logic [3:0] si;
  logic [31:0] sd;

  initial begin
    fr[0] = '{4'hF, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h8, 4'h0,
              4'h0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    fr[1] = '{default: 4'h0};
    set2(4'h0);
    set3();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(o2_valid), 64'd0);
    check("rst_last", 64'(o2_last), 64'd0);
    check("rst_idx", 64'(o2_idx), 64'd0);
    check("rst_del", 64'(o2_del), 64'd0);
    check("rst_rep", 64'(o2_rep), 64'd0);
    check("rst_cv", 64'(o2_cv), 64'd0);
    check("rst_valid3", 64'(o3_valid), 64'd0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // three candidates: lane0 -> 2, lane1 -> 1, lanes 2,3 tie -> 0
    v3 = 1'b1;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    n = 1;
    while (!o3_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat3", 64'(n), 64'd6);
    check("idx3", 64'(o3_idx), 64'h06);
    check("del3", 64'(o3_del), 64'h0000FFFF);

    // tie beat
    set2(4'h0);
    v2 = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    n = 1;
    while (!o2_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat_tie", 64'(n), 64'd5);
    check("idx_tie", 64'(o2_idx), 64'h0);
    check("del_tie", 64'(o2_del), 64'h0);
    @(posedge clk);
    #1;

    // candidate 1 better in every lane
    set2(4'hF);
    v2 = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    n = 1;
    while (!o2_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat_win", 64'(n), 64'd5);
    check("idx_win", 64'(o2_idx), 64'hF);
    check("del_win", 64'(o2_del), 64'hFFFFFFFF);

    // asynchronous reset mid-frame while an output beat is showing
    aresetn = 1'b0;
    #1;
    check("ares_valid", 64'(o2_valid), 64'd0);
    check("ares_idx", 64'(o2_idx), 64'd0);
    check("ares_del", 64'(o2_del), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    mon_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 16; b++) begin
        set2(fr[f][b]);
        v2 = 1'b1;
        q.push_back(fr[f][b]);
        @(posedge clk);
        #1;
        v2 = 1'b0;
        if (b == 3) begin
          @(posedge clk);
          #1;
        end
        if (f == 0 && b == 7) begin
          stall2 = 1'b1;
          sv = o2_valid;
          si = o2_idx;
          sd = o2_del;
          repeat (7) @(posedge clk);
          #1;
          check("stall_valid", 64'(o2_valid), 64'(sv));
          check("stall_idx", 64'(o2_idx), 64'(si));
          check("stall_del", 64'(o2_del), 64'(sd));
          stall2 = 1'b0;
        end
      end
    end
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", 64'(q.size()), 64'd0);
    check("beats_seen", 64'(seen), 64'd32);
    check("pulses", 64'(pulses), 64'd2);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
